// File: rtl/tl_ul_pkg.sv
// TileLink-UL field widths, opcodes and beat structs shared by the buffer slice.
package tl_ul_pkg;

    localparam int unsigned TL_AW        = 32;
    localparam int unsigned TL_DW        = 32;
    localparam int unsigned TL_MW        = TL_DW / 8;
    localparam int unsigned TL_SZW       = 2;
    localparam int unsigned TL_A_OPW     = 3;
    localparam int unsigned TL_A_PARAMW  = 3;
    localparam int unsigned TL_D_OPW     = 3;
    localparam int unsigned TL_D_PARAMW  = 2;
    localparam int unsigned TL_SINKW     = 1;
    // Widest source ID the slice can carry; narrower IDs sit in the low bits.
    localparam int unsigned TL_SRC_MAX_W = 8;

    typedef enum logic [TL_A_OPW-1:0] {
        PUT_FULL_DATA    = 3'd0,
        PUT_PARTIAL_DATA = 3'd1,
        GET              = 3'd4
    } tl_a_op_e;

    typedef enum logic [TL_D_OPW-1:0] {
        ACCESS_ACK      = 3'd0,
        ACCESS_ACK_DATA = 3'd1
    } tl_d_op_e;

    // Opcodes are kept as raw vectors: the slice never decodes them.
    typedef struct packed {
        logic [TL_A_OPW-1:0]     opcode;
        logic [TL_A_PARAMW-1:0]  param;
        logic [TL_SZW-1:0]       size;
        logic [TL_SRC_MAX_W-1:0] source;
        logic [TL_AW-1:0]        address;
        logic [TL_MW-1:0]        mask;
        logic [TL_DW-1:0]        data;
        logic                    corrupt;
    } tl_a_t;

    typedef struct packed {
        logic [TL_D_OPW-1:0]     opcode;
        logic [TL_D_PARAMW-1:0]  param;
        logic [TL_SZW-1:0]       size;
        logic [TL_SRC_MAX_W-1:0] source;
        logic [TL_SINKW-1:0]     sink;
        logic                    denied;
        logic [TL_DW-1:0]        data;
        logic                    corrupt;
    } tl_d_t;

endpackage

// File: rtl/tl_ul_fifo.sv
// Circular FIFO with registered-only ready/valid; head entry drives the output directly.
module tl_ul_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = logic
) (
    input  logic clock,
    input  logic reset_n,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // A full FIFO refuses input even when it is popping this cycle.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign out_data  = mem[head];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Storage, pointer and occupancy update; pointers wrap by explicit compare.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail] <= in_data;
                tail      <= (tail == LAST) ? '0 : tail + 1'b1;
            end
            if (pop) begin
                head <= (head == LAST) ? '0 : head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tl_ul_slice.sv
// Registered TL-UL A/D buffer slice with outstanding-request throttle and idle report.
module tl_ul_slice
    import tl_ul_pkg::*;
#(
    parameter int unsigned DEPTH_A      = 2,
    parameter int unsigned DEPTH_D      = 2,
    parameter int unsigned SOURCE_W     = 1,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                a_in_valid,
    output logic                a_in_ready,
    input  logic [2:0]          a_in_opcode,
    input  logic [2:0]          a_in_param,
    input  logic [1:0]          a_in_size,
    input  logic [SOURCE_W-1:0] a_in_source,
    input  logic [31:0]         a_in_address,
    input  logic [3:0]          a_in_mask,
    input  logic [31:0]         a_in_data,
    input  logic                a_in_corrupt,
    output logic                a_out_valid,
    input  logic                a_out_ready,
    output logic [2:0]          a_out_opcode,
    output logic [2:0]          a_out_param,
    output logic [1:0]          a_out_size,
    output logic [SOURCE_W-1:0] a_out_source,
    output logic [31:0]         a_out_address,
    output logic [3:0]          a_out_mask,
    output logic [31:0]         a_out_data,
    output logic                a_out_corrupt,
    input  logic                d_in_valid,
    output logic                d_in_ready,
    input  logic [2:0]          d_in_opcode,
    input  logic [1:0]          d_in_param,
    input  logic [1:0]          d_in_size,
    input  logic [SOURCE_W-1:0] d_in_source,
    input  logic                d_in_sink,
    input  logic                d_in_denied,
    input  logic [31:0]         d_in_data,
    input  logic                d_in_corrupt,
    output logic                d_out_valid,
    input  logic                d_out_ready,
    output logic [2:0]          d_out_opcode,
    output logic [1:0]          d_out_param,
    output logic [1:0]          d_out_size,
    output logic [SOURCE_W-1:0] d_out_source,
    output logic                d_out_sink,
    output logic                d_out_denied,
    output logic [31:0]         d_out_data,
    output logic                d_out_corrupt,
    output logic [7:0]          inflight,
    output logic                idle
);

    tl_a_t a_in_pl;
    tl_a_t a_out_pl;
    tl_d_t d_in_pl;
    tl_d_t d_out_pl;
    logic  a_fifo_valid;
    logic  below_max;
    logic  a_fire;
    logic  d_fire;
    logic  unused_source;

    // Pack the A beat; SOURCE_W (at most TL_SRC_MAX_W) occupies the low source bits.
    always_comb begin
        a_in_pl                       = '0;
        a_in_pl.opcode                = a_in_opcode;
        a_in_pl.param                 = a_in_param;
        a_in_pl.size                  = a_in_size;
        a_in_pl.source[SOURCE_W-1:0]  = a_in_source;
        a_in_pl.address               = a_in_address;
        a_in_pl.mask                  = a_in_mask;
        a_in_pl.data                  = a_in_data;
        a_in_pl.corrupt               = a_in_corrupt;
    end

    // Pack the D beat the same way.
    always_comb begin
        d_in_pl                       = '0;
        d_in_pl.opcode                = d_in_opcode;
        d_in_pl.param                 = d_in_param;
        d_in_pl.size                  = d_in_size;
        d_in_pl.source[SOURCE_W-1:0]  = d_in_source;
        d_in_pl.sink                  = d_in_sink;
        d_in_pl.denied                = d_in_denied;
        d_in_pl.data                  = d_in_data;
        d_in_pl.corrupt               = d_in_corrupt;
    end

    assign below_max   = (inflight < 8'(MAX_INFLIGHT));
    assign a_out_valid = a_fifo_valid & below_max;
    assign a_fire      = a_out_valid & a_out_ready;
    assign d_fire      = d_out_valid & d_out_ready;

    tl_ul_fifo #(
        .DEPTH (DEPTH_A),
        .T     (tl_a_t)
    ) u_a_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_pl),
        .out_valid (a_fifo_valid),
        .out_ready (a_out_ready & below_max),
        .out_data  (a_out_pl)
    );

    tl_ul_fifo #(
        .DEPTH (DEPTH_D),
        .T     (tl_d_t)
    ) u_d_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .in_data   (d_in_pl),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .out_data  (d_out_pl)
    );

    assign a_out_opcode  = a_out_pl.opcode;
    assign a_out_param   = a_out_pl.param;
    assign a_out_size    = a_out_pl.size;
    assign a_out_source  = a_out_pl.source[SOURCE_W-1:0];
    assign a_out_address = a_out_pl.address;
    assign a_out_mask    = a_out_pl.mask;
    assign a_out_data    = a_out_pl.data;
    assign a_out_corrupt = a_out_pl.corrupt;

    assign d_out_opcode  = d_out_pl.opcode;
    assign d_out_param   = d_out_pl.param;
    assign d_out_size    = d_out_pl.size;
    assign d_out_source  = d_out_pl.source[SOURCE_W-1:0];
    assign d_out_sink    = d_out_pl.sink;
    assign d_out_denied  = d_out_pl.denied;
    assign d_out_data    = d_out_pl.data;
    assign d_out_corrupt = d_out_pl.corrupt;

    // Upper source bits are always zero and intentionally dropped.
    assign unused_source = ^{a_out_pl.source, d_out_pl.source};

    // Outstanding count: up on A issue, down on D return, saturating at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
        end else if (a_fire && !d_fire) begin
            inflight <= inflight + 8'd1;
        end else if (d_fire && !a_fire && (inflight != '0)) begin
            inflight <= inflight - 8'd1;
        end
    end

    assign idle = !a_fifo_valid && !d_out_valid && (inflight == '0);

endmodule

// File: tb/tb_tl_ul_slice.sv
// Randomized bench for tl_ul_slice against a queue-based transaction model.
module tb_tl_ul_slice;

    localparam int DEPTH_A  = 2;
    localparam int DEPTH_D  = 3;
    localparam int SRC_W    = 2;
    localparam int MAX_INFL = 4;

    typedef struct packed {
        logic [2:0]       opcode;
        logic [2:0]       param;
        logic [1:0]       size;
        logic [SRC_W-1:0] source;
        logic [31:0]      address;
        logic [3:0]       mask;
        logic [31:0]      data;
        logic             corrupt;
    } a_beat_t;

    typedef struct packed {
        logic [2:0]       opcode;
        logic [1:0]       param;
        logic [1:0]       size;
        logic [SRC_W-1:0] source;
        logic             sink;
        logic             denied;
        logic [31:0]      data;
        logic             corrupt;
    } d_beat_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic a_in_valid = 1'b0, a_out_ready = 1'b0, d_in_valid = 1'b0, d_out_ready = 1'b0;
    a_beat_t a_in = '0;
    d_beat_t d_in = '0;

    logic             a_in_ready, a_out_valid, d_in_ready, d_out_valid, idle;
    logic [2:0]       a_out_opcode, a_out_param, d_out_opcode;
    logic [1:0]       a_out_size, d_out_param, d_out_size;
    logic [SRC_W-1:0] a_out_source, d_out_source;
    logic [31:0]      a_out_address, a_out_data, d_out_data;
    logic [3:0]       a_out_mask;
    logic             a_out_corrupt, d_out_sink, d_out_denied, d_out_corrupt;
    logic [7:0]       inflight;

    always #5 clock = ~clock;

    tl_ul_slice #(
        .DEPTH_A      (DEPTH_A),
        .DEPTH_D      (DEPTH_D),
        .SOURCE_W     (SRC_W),
        .MAX_INFLIGHT (MAX_INFL)
    ) dut (
        .clock (clock), .reset_n (reset_n),
        .a_in_valid (a_in_valid), .a_in_ready (a_in_ready),
        .a_in_opcode (a_in.opcode), .a_in_param (a_in.param), .a_in_size (a_in.size),
        .a_in_source (a_in.source), .a_in_address (a_in.address), .a_in_mask (a_in.mask),
        .a_in_data (a_in.data), .a_in_corrupt (a_in.corrupt),
        .a_out_valid (a_out_valid), .a_out_ready (a_out_ready),
        .a_out_opcode (a_out_opcode), .a_out_param (a_out_param), .a_out_size (a_out_size),
        .a_out_source (a_out_source), .a_out_address (a_out_address), .a_out_mask (a_out_mask),
        .a_out_data (a_out_data), .a_out_corrupt (a_out_corrupt),
        .d_in_valid (d_in_valid), .d_in_ready (d_in_ready),
        .d_in_opcode (d_in.opcode), .d_in_param (d_in.param), .d_in_size (d_in.size),
        .d_in_source (d_in.source), .d_in_sink (d_in.sink), .d_in_denied (d_in.denied),
        .d_in_data (d_in.data), .d_in_corrupt (d_in.corrupt),
        .d_out_valid (d_out_valid), .d_out_ready (d_out_ready),
        .d_out_opcode (d_out_opcode), .d_out_param (d_out_param), .d_out_size (d_out_size),
        .d_out_source (d_out_source), .d_out_sink (d_out_sink), .d_out_denied (d_out_denied),
        .d_out_data (d_out_data), .d_out_corrupt (d_out_corrupt),
        .inflight (inflight), .idle (idle)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transaction model: beats waiting in each channel plus the outstanding count.
    a_beat_t qa[$];
    d_beat_t qd[$];
    int      m_infl = 0;
    logic    m_a_acc, m_a_pop, m_d_acc, m_d_pop, dut_a_fire, dut_d_fire;
    a_beat_t m_a_popped;

    function automatic a_beat_t obs_a();
        return {a_out_opcode, a_out_param, a_out_size, a_out_source, a_out_address,
                a_out_mask, a_out_data, a_out_corrupt};
    endfunction

    function automatic d_beat_t obs_d();
        return {d_out_opcode, d_out_param, d_out_size, d_out_source, d_out_sink,
                d_out_denied, d_out_data, d_out_corrupt};
    endfunction

    function automatic a_beat_t get_beat(input logic [31:0] addr, input logic [SRC_W-1:0] src);
        a_beat_t b = '0;
        b.opcode = 3'd4; b.size = 2'd2; b.source = src; b.address = addr; b.mask = 4'hf;
        return b;
    endfunction

    function automatic a_beat_t rand_a();
        a_beat_t b;
        b = {$urandom, $urandom, $urandom};
        return b;
    endfunction

    function automatic d_beat_t rand_d();
        d_beat_t b;
        b = {$urandom, $urandom};
        return b;
    endfunction

    function automatic d_beat_t ack_data(input logic [SRC_W-1:0] src, input logic [31:0] data);
        d_beat_t b = '0;
        b.opcode = 3'd1; b.size = 2'd2; b.source = src; b.data = data;
        return b;
    endfunction

    task automatic check_outputs();
        logic exp_av;
        exp_av = (qa.size() != 0) && (m_infl < MAX_INFL);
        check_eq("a_in_ready", 96'(a_in_ready), 96'(qa.size() != DEPTH_A));
        check_eq("a_out_valid", 96'(a_out_valid), 96'(exp_av));
        if (qa.size() != 0) check_eq("a_out_beat", 96'(obs_a()), 96'(qa[0]));
        check_eq("d_in_ready", 96'(d_in_ready), 96'(qd.size() != DEPTH_D));
        check_eq("d_out_valid", 96'(d_out_valid), 96'(qd.size() != 0));
        if (qd.size() != 0) check_eq("d_out_beat", 96'(obs_d()), 96'(qd[0]));
        check_eq("inflight", 96'(inflight), 96'(m_infl));
        check_eq("idle", 96'(idle), 96'(qa.size() == 0 && qd.size() == 0 && m_infl == 0));
    endtask

    // One clock: check the state left by the last edge, then drive and advance the model.
    task automatic step(input logic av, input a_beat_t ab, input logic ar,
                        input logic dv, input d_beat_t db, input logic dr);
        @(negedge clock);
        check_outputs();
        dut_a_fire = a_out_valid && ar;
        dut_d_fire = d_out_valid && dr;
        a_in_valid = av; a_in = ab; a_out_ready = ar;
        d_in_valid = dv; d_in = db; d_out_ready = dr;
        m_a_acc = av && (qa.size() < DEPTH_A);
        m_a_pop = ar && (qa.size() > 0) && (m_infl < MAX_INFL);
        m_d_acc = dv && (qd.size() < DEPTH_D);
        m_d_pop = dr && (qd.size() > 0);
        if (m_a_pop) begin
            m_a_popped = qa[0];
            void'(qa.pop_front());
        end
        if (m_a_acc) qa.push_back(ab);
        if (m_d_pop) void'(qd.pop_front());
        if (m_d_acc) qd.push_back(db);
        if (m_a_pop && !m_d_pop) m_infl++;
        else if (m_d_pop && !m_a_pop && m_infl > 0) m_infl--;
    endtask

    task automatic reset_checks(input string tag);
        check_eq({tag, "_a_out_valid"}, 96'(a_out_valid), 96'(0));
        check_eq({tag, "_d_out_valid"}, 96'(d_out_valid), 96'(0));
        check_eq({tag, "_a_in_ready"}, 96'(a_in_ready), 96'(1));
        check_eq({tag, "_d_in_ready"}, 96'(d_in_ready), 96'(1));
        check_eq({tag, "_inflight"}, 96'(inflight), 96'(0));
        check_eq({tag, "_idle"}, 96'(idle), 96'(1));
        check_eq({tag, "_a_payload"}, 96'(obs_a()), 96'(0));
        check_eq({tag, "_d_payload"}, 96'(obs_d()), 96'(0));
    endtask

    // Return outstanding requests until the slice goes idle.
    task automatic drain();
        for (int c = 0; c < 100; c++) begin
            if (qa.size() == 0 && qd.size() == 0 && m_infl == 0) break;
            step(1'b0, '0, 1'b1, m_infl > qd.size(), ack_data('0, $urandom), 1'b1);
        end
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        check_eq("drain_idle", 96'(idle), 96'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, fires, first_fire, last_fire, cyc, got;
        d_beat_t pend[$];
        a_beat_t bp[3];

        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1 reset_checks("por");

        // Reset with a beat buffered in each channel.
        step(1'b1, rand_a(), 1'b0, 1'b1, rand_d(), 1'b0);
        @(negedge clock);
        check_eq("rst_pre_a_valid", 96'(a_out_valid), 96'(1));
        check_eq("rst_pre_d_valid", 96'(d_out_valid), 96'(1));
        a_in_valid = 1'b0; d_in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1 reset_checks("rst_async");
        qa.delete(); qd.delete(); m_infl = 0;
        @(negedge clock);
        reset_n = 1'b1;
        #1 reset_checks("rst_rel");

        // Back-to-back Get stream, fabric answering one cycle after each issue.
        sent = 0; fires = 0; first_fire = -1; last_fire = -1;
        for (cyc = 0; cyc < 60; cyc++) begin
            logic dv;
            d_beat_t db;
            if (sent == 8 && qa.size() == 0 && qd.size() == 0 && m_infl == 0 && pend.size() == 0) break;
            dv = pend.size() > 0;
            db = dv ? pend[0] : '0;
            step(sent < 8, get_beat(32'h1000 + 32'(4 * sent), '0), 1'b1, dv, db, 1'b1);
            check_eq("stream_infl_le2", 96'(inflight <= 8'd2), 96'(1));
            if (m_d_acc) void'(pend.pop_front());
            if (dut_a_fire) begin
                fires++;
                if (first_fire < 0) first_fire = cyc;
                last_fire = cyc;
                pend.push_back(ack_data(m_a_popped.source, $urandom));
            end
            if (m_a_acc) sent++;
        end
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        check_eq("stream_fires", 96'(fires), 96'(8));
        check_eq("stream_span", 96'(last_fire - first_fire), 96'(7));
        check_eq("stream_infl_zero", 96'(inflight), 96'(0));

        // Backpressure on A with a two-entry FIFO.
        for (int i = 0; i < 3; i++) bp[i] = rand_a();
        step(1'b1, bp[0], 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, bp[1], 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, bp[2], 1'b0, 1'b0, '0, 1'b0);
        check_eq("bp_full", 96'(a_in_ready), 96'(0));
        step(1'b1, bp[2], 1'b1, 1'b0, '0, 1'b0);
        check_eq("bp_still_full", 96'(a_in_ready), 96'(0));
        check_eq("bp_head_beat0", 96'(obs_a()), 96'(bp[0]));
        step(1'b1, bp[2], 1'b0, 1'b0, '0, 1'b0);
        check_eq("bp_ready_back", 96'(a_in_ready), 96'(1));
        drain();

        // Throttle at MAX_INFLIGHT with no responses, then release by one D.
        sent = 0; fires = 0;
        for (int c = 0; c < 12; c++) begin
            step(sent < 6, get_beat(32'h2000 + 32'(4 * sent), SRC_W'(sent)), 1'b1, 1'b0, '0, 1'b0);
            if (m_a_acc) sent++;
            if (dut_a_fire) fires++;
        end
        check_eq("thr_fires", 96'(fires), 96'(4));
        check_eq("thr_infl", 96'(inflight), 96'(4));
        check_eq("thr_blocked", 96'(a_out_valid), 96'(0));
        step(1'b0, '0, 1'b1, 1'b1, ack_data('0, 32'hDEADBEEF), 1'b1);
        check_eq("thr_pre_valid", 96'(a_out_valid), 96'(0));
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        check_eq("thr_d_data", 96'(d_out_data), 96'(32'hDEADBEEF));
        check_eq("thr_held", 96'(a_out_valid), 96'(0));
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        check_eq("thr_release", 96'(a_out_valid), 96'(1));
        check_eq("thr_infl3", 96'(inflight), 96'(3));
        drain();

        // Simultaneous A and D fire at inflight 3.
        for (int i = 0; i < 3; i++) bp[i] = rand_a();
        step(1'b1, bp[0], 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, bp[1], 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, bp[2], 1'b1, 1'b0, '0, 1'b0);
        step(1'b1, rand_a(), 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, ack_data('0, $urandom), 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        check_eq("sim_pre_infl", 96'(inflight), 96'(3));
        check_eq("sim_pre_a", 96'(a_out_valid & d_out_valid), 96'(1));
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        check_eq("sim_infl", 96'(inflight), 96'(3));
        drain();

        // D wrap-around through three entries with random stalls; inflight stays at 0.
        sent = 0; got = 0;
        for (int c = 0; c < 200; c++) begin
            if (sent == 10 && qd.size() == 0) break;
            step(1'b0, '0, 1'b0, (sent < 10) && ($urandom_range(0, 3) != 0), rand_d(), 1'($urandom));
            if (m_d_acc) sent++;
            if (dut_d_fire) got++;
        end
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        check_eq("wrap_count", 96'(got), 96'(10));
        check_eq("wrap_infl_sat", 96'(inflight), 96'(0));

        // Fully random traffic on both channels.
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom), rand_a(), 1'($urandom), 1'($urandom), rand_d(), 1'($urandom));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
